// File: rtl/instr_issue.sv
`default_nettype none
// instr_issue: fetch/issue stage of the 2-stage 4-bit CPU.
// Holds PC and IR, resolves 111x jumps with one shadow cycle, and injects bubbles for stall and halt.
module instr_issue #(
  parameter int ADDR_W   = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              zero_flag,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        D_BUS,
  output logic              issue_valid,
  output logic [ADDR_W-1:0] ir_addr,
  output logic              flush,
  output logic              halted
);

  typedef enum logic {
    PH_NORMAL = 1'b0,
    PH_SHADOW = 1'b1
  } phase_t;

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ir_addr_q, ir_addr_d;
  logic [7:0]        ir_q, ir_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  phase_t            phase_q, phase_d;

  logic              jump_issue;
  logic              jump_taken;
  logic [ADDR_W-1:0] jump_target;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q      <= PC_INIT;
      ir_addr_q <= '0;
      ir_q      <= 8'h00;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      phase_q   <= PH_NORMAL;
    end else begin
      pc_q      <= pc_d;
      ir_addr_q <= ir_addr_d;
      ir_q      <= ir_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      phase_q   <= phase_d;
    end
  end

  // IR[4] distinguishes JZ (1) from JMP (0); JMP is unconditional.
  assign jump_issue  = (phase_q == PH_NORMAL) && valid_q && (ir_q[7:5] == 3'b111);
  assign jump_taken  = !ir_q[4] || zero_flag;
  assign jump_target = ADDR_W'(ir_q[3:0]);

  always_comb begin
    pc_d      = pc_q;
    ir_addr_d = ir_addr_q;
    ir_d      = 8'h00;
    valid_d   = 1'b0;
    halted_d  = halted_q;
    phase_d   = phase_q;

    if (halted_q) begin
      // Frozen: bubbles forever, pc and phase untouched until reset.
    end else if (jump_issue) begin
      phase_d = PH_SHADOW;
      if (jump_taken) begin
        pc_d = jump_target;
      end
      if (!ir_q[4] && (jump_target == ir_addr_q)) begin
        halted_d = 1'b1;
      end
    end else begin
      phase_d = PH_NORMAL;
      if (run) begin
        ir_d      = rom_data;
        ir_addr_d = pc_q;
        valid_d   = 1'b1;
        pc_d      = pc_q + ADDR_W'(1);
      end
    end
  end

  assign rom_addr    = pc_q;
  assign D_BUS       = ir_q;
  assign issue_valid = valid_q;
  assign ir_addr     = ir_addr_q;
  assign flush       = (phase_q == PH_SHADOW);
  assign halted      = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_issue.sv
`default_nettype none
// tb_instr_issue: scoreboard bench for instr_issue; each step queues the expected post-edge outputs.
module tb_instr_issue;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       zero_flag = 1'b0;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] D_BUS;
  logic       issue_valid;
  logic [3:0] ir_addr;
  logic       flush;
  logic       halted;

  logic [7:0] rom [16];

  typedef struct packed {
    logic [7:0] bus;
    logic       valid;
    logic [3:0] addr;
    logic       flsh;
    logic       hlt;
    logic [3:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  instr_issue #(.ADDR_W(4), .RESET_PC(0)) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .zero_flag   (zero_flag),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .D_BUS       (D_BUS),
    .issue_valid (issue_valid),
    .ir_addr     (ir_addr),
    .flush       (flush),
    .halted      (halted)
  );

  assign rom_data = rom[rom_addr];

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".bus"},    32'(D_BUS),       32'h00);
    check_val({tag, ".valid"},  32'(issue_valid), 32'h0);
    check_val({tag, ".iraddr"}, 32'(ir_addr),     32'h0);
    check_val({tag, ".flush"},  32'(flush),       32'h0);
    check_val({tag, ".halted"}, 32'(halted),      32'h0);
    check_val({tag, ".pc"},     32'(rom_addr),    32'h0);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Drive one cycle of inputs, queue what the bus must show after the edge, then compare.
  task automatic step(input string tag, input logic r, input logic zf,
                      input logic [7:0] eb, input logic ev, input logic [3:0] ea,
                      input logic ef, input logic eh, input logic [3:0] epc);
    exp_t e;
    run       = r;
    zero_flag = zf;
    exp_q.push_back('{bus: eb, valid: ev, addr: ea, flsh: ef, hlt: eh, pc: epc});
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check_val({tag, ".bus"},    32'(D_BUS),       32'(e.bus));
    check_val({tag, ".valid"},  32'(issue_valid), 32'(e.valid));
    check_val({tag, ".iraddr"}, 32'(ir_addr),     32'(e.addr));
    check_val({tag, ".flush"},  32'(flush),       32'(e.flsh));
    check_val({tag, ".halted"}, 32'(halted),      32'(e.hlt));
    check_val({tag, ".pc"},     32'(rom_addr),    32'(e.pc));
  endtask

  initial begin
    clear_rom();
    #2;
    check_reset_outputs("por");

    // Straight-line fetch
    rom[0] = 8'h15; rom[1] = 8'h42; rom[2] = 8'h83; rom[3] = 8'hC0;
    do_reset("rst1");
    step("t1c1", 1, 0, 8'h15, 1, 4'd0, 0, 0, 4'd1);
    step("t1c2", 1, 0, 8'h42, 1, 4'd1, 0, 0, 4'd2);
    step("t1c3", 1, 0, 8'h83, 1, 4'd2, 0, 0, 4'd3);
    step("t1c4", 1, 0, 8'hC0, 1, 4'd3, 0, 0, 4'd4);

    // JMP 7
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h42; rom[2] = 8'hE7; rom[7] = 8'h21;
    do_reset("rst2");
    step("t2c1", 1, 0, 8'h15, 1, 4'd0, 0, 0, 4'd1);
    step("t2c2", 1, 0, 8'h42, 1, 4'd1, 0, 0, 4'd2);
    step("t2jmp", 1, 0, 8'hE7, 1, 4'd2, 0, 0, 4'd3);
    step("t2shd", 1, 0, 8'h00, 0, 4'd2, 1, 0, 4'd7);
    step("t2tgt", 1, 0, 8'h21, 1, 4'd7, 0, 0, 4'd8);

    // JZ not taken, then JZ taken; zero_flag outside the issue cycle is irrelevant
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'hF9; rom[2] = 8'h33; rom[3] = 8'hF9; rom[9] = 8'h44;
    do_reset("rst3");
    step("t3c1", 1, 1, 8'h15, 1, 4'd0, 0, 0, 4'd1);
    step("t3jz0", 1, 1, 8'hF9, 1, 4'd1, 0, 0, 4'd2);
    step("t3shd0", 1, 0, 8'h00, 0, 4'd1, 1, 0, 4'd2);
    step("t3nt", 1, 1, 8'h33, 1, 4'd2, 0, 0, 4'd3);
    step("t3jz1", 1, 0, 8'hF9, 1, 4'd3, 0, 0, 4'd4);
    step("t3shd1", 1, 1, 8'h00, 0, 4'd3, 1, 0, 4'd9);
    step("t3tk", 1, 0, 8'h44, 1, 4'd9, 0, 0, 4'd10);

    // Stalls, stall during jump issue, stall during shadow
    clear_rom();
    rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'hE6; rom[6] = 8'h66; rom[7] = 8'h77;
    rom[10] = 8'hEC; rom[12] = 8'hCC;
    do_reset("rst4");
    step("t4c1", 1, 0, 8'h11, 1, 4'd0, 0, 0, 4'd1);
    for (int i = 0; i < 3; i++) step("t4stl", 0, 0, 8'h00, 0, 4'd0, 0, 0, 4'd1);
    step("t4res", 1, 0, 8'h22, 1, 4'd1, 0, 0, 4'd2);
    step("t4jmp", 1, 0, 8'hE6, 1, 4'd2, 0, 0, 4'd3);
    step("t4shd", 0, 0, 8'h00, 0, 4'd2, 1, 0, 4'd6);
    step("t4tgt", 1, 0, 8'h66, 1, 4'd6, 0, 0, 4'd7);
    step("t4nxt", 1, 0, 8'h77, 1, 4'd7, 0, 0, 4'd8);

    // Shadow cycle with run=0 collapses into a bubble, pc holds at target
    rom[8] = 8'hEC;
    step("t5jmp", 1, 0, 8'hEC, 1, 4'd8, 0, 0, 4'd9);
    step("t5shd", 1, 0, 8'h00, 0, 4'd8, 1, 0, 4'd12);
    step("t5stl", 0, 0, 8'h00, 0, 4'd8, 0, 0, 4'd12);
    step("t5tgt", 1, 0, 8'hCC, 1, 4'd12, 0, 0, 4'd13);

    // JMP to self halts; halted ignores run until reset
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = 8'h10 + 8'(i);
    rom[5] = 8'hE5;
    do_reset("rst6");
    for (int i = 0; i < 5; i++)
      step("t6lin", 1, 0, 8'h10 + 8'(i), 1, 4'(i), 0, 0, 4'(i + 1));
    step("t6jmp", 1, 0, 8'hE5, 1, 4'd5, 0, 0, 4'd6);
    step("t6hlt", 1, 0, 8'h00, 0, 4'd5, 1, 1, 4'd5);
    step("t6hr1", 1, 1, 8'h00, 0, 4'd5, 1, 1, 4'd5);
    step("t6hr0", 0, 0, 8'h00, 0, 4'd5, 1, 1, 4'd5);
    do_reset("rst6b");

    // PC wrap through 15 back to 0
    clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h20 + 8'(i);
    do_reset("rst7");
    for (int i = 0; i < 18; i++)
      step("t7wrap", 1, 0, 8'h20 + 8'((i % 16)), 1, 4'(i % 16), 0, 0, 4'((i + 1) % 16));

    // Async reset in the middle of a shadow cycle
    rom[0] = 8'hEA;
    do_reset("rst8");
    step("t8jmp", 1, 0, 8'hEA, 1, 4'd0, 0, 0, 4'd1);
    step("t8shd", 1, 0, 8'h00, 0, 4'd0, 1, 0, 4'd10);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("t8async");
    #2;
    reset = 1'b1;
    step("t8refetch", 1, 0, 8'hEA, 1, 4'd0, 0, 0, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
